// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer
//  Description : Control sequencer for branch instructions. Decodes B, BL,
//                B.cond, CBZ, CBNZ and BR, evaluates the branch condition
//                against a registered {V,C,Z,N} flags register, and drives
//                the PC-select / register-write controls through a short
//                IDLE -> EVAL -> (LINK) -> DONE sequence. Keeps saturating
//                counts of legal and taken branches.
//
//  Ports       :
//    clock         rising-edge clock
//    reset_n       asynchronous active-low reset
//    start         request to sequence the instruction (sampled in IDLE)
//    instruction   branch instruction, stable from start until done
//    status_in     {V,C,Z,N} from the ALU
//    status_load   load status_in into the flags register
//    reg_zero      register read on SB is zero (CBZ/CBNZ)
//    Psel          PC source: 00 hold, 01 PC+4, 11 PC+4+K*4, 10 PC from bus
//    PCsel         relative-branch target select
//    regW          register-file write enable
//    EN_PC         PC-to-bus enable
//    DA, SB        destination / source-B register addresses
//    K             sign-extended branch offset (K_WIDTH bits, must be > 26)
//    busy, done    sequence in progress / one-cycle completion pulse
//    illegal       undecodable opcode seen in EVAL
//    flags         registered {V,C,Z,N}
//    branch_cnt    saturating count of legal branches
//    taken_cnt     saturating count of taken branches
//
//  Revision    : 1.0  initial release
// ============================================================================
module branch_sequencer #(
    parameter int K_WIDTH   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          instruction,
    input  logic [3:0]           status_in,
    input  logic                 status_load,
    input  logic                 reg_zero,
    output logic [1:0]           Psel,
    output logic                 PCsel,
    output logic                 regW,
    output logic                 EN_PC,
    output logic [4:0]           DA,
    output logic [4:0]           SB,
    output logic [K_WIDTH-1:0]   K,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [3:0]           flags,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam logic [4:0]           c_reg_none = 5'b11111;
    localparam logic [4:0]           c_reg_link = 5'd30;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    localparam logic [1:0] c_psel_hold = 2'b00;
    localparam logic [1:0] c_psel_inc  = 2'b01;
    localparam logic [1:0] c_psel_bus  = 2'b10;
    localparam logic [1:0] c_psel_rel  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_LINK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_flags;
    logic [CNT_WIDTH-1:0]   r_branch_cnt;
    logic [CNT_WIDTH-1:0]   r_taken_cnt;

    logic                   w_is_b;
    logic                   w_is_bl;
    logic                   w_is_bcond;
    logic                   w_is_cbz;
    logic                   w_is_cbnz;
    logic                   w_is_br;
    logic                   w_legal;
    logic                   w_cond_true;
    logic                   w_taken;
    logic [K_WIDTH-1:0]     w_k;

    // flags layout {V,C,Z,N}
    logic w_v, w_c, w_z, w_n;
    assign w_v = r_flags[3];
    assign w_c = r_flags[2];
    assign w_z = r_flags[1];
    assign w_n = r_flags[0];

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    assign w_is_b     = (instruction[31:26] == 6'b000101);
    assign w_is_bl    = (instruction[31:26] == 6'b100101);
    assign w_is_bcond = (instruction[31:24] == 8'b01010100);
    assign w_is_cbz   = (instruction[31:24] == 8'b10110100);
    assign w_is_cbnz  = (instruction[31:24] == 8'b10110101);
    assign w_is_br    = (instruction[31:21] == 11'b11010110000);
    assign w_legal    = w_is_b | w_is_bl | w_is_bcond | w_is_cbz | w_is_cbnz | w_is_br;

    // ------------------------------------------------------------------
    // Offset sign extension
    // ------------------------------------------------------------------
    always_comb begin
        w_k = '0;
        if (w_is_b || w_is_bl) begin
            w_k = {{(K_WIDTH-26){instruction[25]}}, instruction[25:0]};
        end else if (w_is_bcond || w_is_cbz || w_is_cbnz) begin
            w_k = {{(K_WIDTH-19){instruction[23]}}, instruction[23:5]};
        end
    end

    // K is held at zero while reset is asserted.
    assign K = reset_n ? w_k : '0;

    // ------------------------------------------------------------------
    // Condition evaluation on the registered flags. Because r_flags is the
    // register output, a status_load in the EVAL cycle only takes effect
    // after the decision has been made.
    // ------------------------------------------------------------------
    always_comb begin
        w_cond_true = 1'b1;
        case (instruction[3:0])
            4'h0:    w_cond_true = w_z;
            4'h1:    w_cond_true = ~w_z;
            4'h2:    w_cond_true = w_c;
            4'h3:    w_cond_true = ~w_c;
            4'h4:    w_cond_true = w_n;
            4'h5:    w_cond_true = ~w_n;
            4'h6:    w_cond_true = w_v;
            4'h7:    w_cond_true = ~w_v;
            4'h8:    w_cond_true = w_c & ~w_z;
            4'h9:    w_cond_true = ~(w_c & ~w_z);
            4'hA:    w_cond_true = (w_n == w_v);
            4'hB:    w_cond_true = (w_n != w_v);
            4'hC:    w_cond_true = ~w_z & (w_n == w_v);
            4'hD:    w_cond_true = ~(~w_z & (w_n == w_v));
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_taken = w_is_b | w_is_bl | w_is_br
                   | (w_is_bcond & w_cond_true)
                   | (w_is_cbz   &  reg_zero)
                   | (w_is_cbnz  & ~reg_zero);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        Psel        = c_psel_hold;
        PCsel       = 1'b0;
        regW        = 1'b0;
        EN_PC       = 1'b0;
        DA          = c_reg_none;
        SB          = c_reg_none;
        busy        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EVAL;
                end
            end

            S_EVAL: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
                if (!w_legal) begin
                    // Step past the undecodable word.
                    illegal = 1'b1;
                    Psel    = c_psel_inc;
                    EN_PC   = 1'b1;
                end else if (w_is_bl) begin
                    // Write the return address (PC+4 on the bus) into X30,
                    // then jump in LINK.
                    regW        = 1'b1;
                    DA          = c_reg_link;
                    EN_PC       = 1'b1;
                    Psel        = c_psel_hold;
                    w_state_nxt = S_LINK;
                end else begin
                    EN_PC = 1'b1;
                    if (w_is_cbz || w_is_cbnz) begin
                        SB = instruction[4:0];
                    end else if (w_is_br) begin
                        SB = instruction[9:5];
                    end
                    if (w_is_br) begin
                        Psel = c_psel_bus;
                    end else if (w_taken) begin
                        Psel  = c_psel_rel;
                        PCsel = 1'b1;
                    end else begin
                        Psel = c_psel_inc;
                    end
                end
            end

            S_LINK: begin
                busy        = 1'b1;
                Psel        = c_psel_rel;
                PCsel       = 1'b1;
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Flags register: loads whenever requested, regardless of FSM state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= 4'b0000;
        end else if (status_load) begin
            r_flags <= status_in;
        end
    end

    // ------------------------------------------------------------------
    // Saturating branch statistics, updated once in each EVAL
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (r_state == S_EVAL && w_legal) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + c_cnt_one;
            end
        end
    end

    assign flags      = r_flags;
    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_sequencer
//  Description : Self-checking bench for branch_sequencer. Directed scenarios
//                followed by randomized instructions checked against an
//                instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_sequencer;

    localparam int K_WIDTH   = 64;
    localparam int CNT_WIDTH = 2;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    localparam int KB    = 0;
    localparam int KBL   = 1;
    localparam int KBC   = 2;
    localparam int KCBZ  = 3;
    localparam int KCBNZ = 4;
    localparam int KBR   = 5;
    localparam int KILL  = 6;

    logic                 clock;
    logic                 reset_n;
    logic                 start;
    logic [31:0]          instruction;
    logic [3:0]           status_in;
    logic                 status_load;
    logic                 reg_zero;
    logic [1:0]           Psel;
    logic                 PCsel;
    logic                 regW;
    logic                 EN_PC;
    logic [4:0]           DA;
    logic [4:0]           SB;
    logic [K_WIDTH-1:0]   K;
    logic                 busy;
    logic                 done;
    logic                 illegal;
    logic [3:0]           flags;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] taken_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [3:0] m_flags;
    int         m_branch;
    int         m_taken;

    branch_sequencer #(
        .K_WIDTH   (K_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .instruction (instruction),
        .status_in   (status_in),
        .status_load (status_load),
        .reg_zero    (reg_zero),
        .Psel        (Psel),
        .PCsel       (PCsel),
        .regW        (regW),
        .EN_PC       (EN_PC),
        .DA          (DA),
        .SB          (SB),
        .K           (K),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .flags       (flags),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [31:0] i);
        if (i[31:26] == 6'b000101)       return KB;
        if (i[31:26] == 6'b100101)       return KBL;
        if (i[31:24] == 8'b01010100)     return KBC;
        if (i[31:24] == 8'b10110100)     return KCBZ;
        if (i[31:24] == 8'b10110101)     return KCBNZ;
        if (i[31:21] == 11'b11010110000) return KBR;
        return KILL;
    endfunction

    // Conditions come in pairs: odd codes negate the even base test,
    // except 1111 which is "always" like 1110.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit v, cy, z, n, base;
        v = f[3]; cy = f[2]; z = f[1]; n = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[0] && c != 4'hF) return !base;
        return base;
    endfunction

    function automatic longint sext(input longint v, input int bits);
        if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_quiet(input string tag);
        check({tag, "_psel"},  64'(Psel),  64'(0));
        check({tag, "_pcsel"}, 64'(PCsel), 64'(0));
        check({tag, "_regw"},  64'(regW),  64'(0));
        check({tag, "_enpc"},  64'(EN_PC), 64'(0));
        check({tag, "_da"},    64'(DA),    64'(31));
        check({tag, "_sb"},    64'(SB),    64'(31));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_busy",    64'(busy),       64'(0));
        check("rst_done",    64'(done),       64'(0));
        check("rst_illegal", 64'(illegal),    64'(0));
        check("rst_k",       64'(K),          64'(0));
        check("rst_flags",   64'(flags),      64'(0));
        check("rst_bcnt",    64'(branch_cnt), 64'(0));
        check("rst_tcnt",    64'(taken_cnt),  64'(0));
        check_quiet("rst");
        m_flags  = 4'b0000;
        m_branch = 0;
        m_taken  = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic load_flags(input logic [3:0] v);
        @(negedge clock);
        status_in   = v;
        status_load = 1'b1;
        @(negedge clock);
        status_load = 1'b0;
        m_flags     = v;
        check("flags_load", 64'(flags), 64'(v));
    endtask

    // One complete sequence; optionally loads new flags during EVAL and
    // holds start high through EVAL (which must be ignored).
    task automatic run_instr(input logic [31:0] ins, input bit rz,
                             input bit load_in_eval, input logic [3:0] load_val);
        int     kd;
        bit     tk;
        longint kexp;
        int     e_psel, e_pcsel, e_regw, e_da, e_sb;
        kd = kind_of(ins);
        case (kd)
            KB, KBL, KBR: tk = 1'b1;
            KBC:          tk = cond_holds(ins[3:0], m_flags);
            KCBZ:         tk = rz;
            KCBNZ:        tk = !rz;
            default:      tk = 1'b0;
        endcase
        case (kd)
            KB, KBL:         kexp = sext(longint'(ins[25:0]), 26);
            KBC, KCBZ, KCBNZ: kexp = sext(longint'(ins[23:5]), 19);
            default:         kexp = 0;
        endcase
        e_da = 31; e_sb = 31; e_regw = 0; e_pcsel = 0;
        case (kd)
            KILL: e_psel = 1;
            KBL: begin e_psel = 0; e_regw = 1; e_da = 30; end
            KBR: begin e_psel = 2; e_sb = int'(ins[9:5]); end
            default: begin
                e_psel  = tk ? 3 : 1;
                e_pcsel = tk ? 1 : 0;
                if (kd == KCBZ || kd == KCBNZ) e_sb = int'(ins[4:0]);
            end
        endcase

        @(negedge clock);
        instruction = ins;
        reg_zero    = rz;
        start       = 1'b1;
        @(negedge clock);                 // EVAL
        check("eval_busy",    64'(busy),    64'(1));
        check("eval_done",    64'(done),    64'(0));
        check("eval_illegal", 64'(illegal), 64'(kd == KILL));
        check("eval_psel",    64'(Psel),    64'(e_psel));
        check("eval_pcsel",   64'(PCsel),   64'(e_pcsel));
        check("eval_regw",    64'(regW),    64'(e_regw));
        check("eval_da",      64'(DA),      64'(e_da));
        check("eval_sb",      64'(SB),      64'(e_sb));
        check("eval_k",       64'(K),       64'(kexp));
        if (kd != KILL) check("eval_enpc", 64'(EN_PC), 64'(1));
        if (load_in_eval) begin
            status_in   = load_val;
            status_load = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        if (load_in_eval) begin
            status_load = 1'b0;
            m_flags     = load_val;
        end
        if (kd != KILL) begin
            m_branch = sat_inc(m_branch);
            if (tk) m_taken = sat_inc(m_taken);
        end
        if (kd == KBL) begin              // LINK
            check("link_psel",  64'(Psel),  64'(3));
            check("link_pcsel", 64'(PCsel), 64'(1));
            check("link_regw",  64'(regW),  64'(0));
            check("link_busy",  64'(busy),  64'(1));
            check("link_done",  64'(done),  64'(0));
            check("link_k",     64'(K),     64'(kexp));
            @(negedge clock);
        end
        check("done_done", 64'(done), 64'(1));  // DONE
        check("done_busy", 64'(busy), 64'(1));
        check_quiet("done");
        @(negedge clock);                 // back in IDLE
        check("idle_done",  64'(done),       64'(0));
        check("idle_busy",  64'(busy),       64'(0));
        check("idle_flags", 64'(flags),      64'(m_flags));
        check("idle_bcnt",  64'(branch_cnt), 64'(m_branch));
        check("idle_tcnt",  64'(taken_cnt),  64'(m_taken));
        check_quiet("idle");
    endtask

    logic [31:0] rnd;
    logic [31:0] ins;

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        instruction = 32'h0;
        status_in   = 4'h0;
        status_load = 1'b0;
        reg_zero    = 1'b0;
        m_flags     = 4'h0;
        m_branch    = 0;
        m_taken     = 0;
        #2;
        do_reset();

        // B.cond EQ, Z set, imm19 = -1
        load_flags(4'b0010);
        run_instr({8'b01010100, 19'h7FFFF, 1'b0, 4'h0}, 1'b0, 1'b0, 4'h0);

        // B.cond GE with N=1, V=0 -> not taken
        do_reset();
        load_flags(4'b0001);
        run_instr({8'b01010100, 19'h00005, 1'b0, 4'hA}, 1'b0, 1'b0, 4'h0);

        // BL with imm26 = 0x10
        run_instr({6'b100101, 26'h0000010}, 1'b0, 1'b0, 4'h0);

        // CBNZ / CBZ with reg_zero = 1
        run_instr({8'b10110101, 19'h00003, 5'd7}, 1'b1, 1'b0, 4'h0);
        run_instr({8'b10110100, 19'h7FFF0, 5'd9}, 1'b1, 1'b0, 4'h0);

        // status_load in the EVAL cycle must not affect the decision
        load_flags(4'b0010);
        run_instr({8'b01010100, 19'h00100, 1'b0, 4'h0}, 1'b0, 1'b1, 4'b0000);

        // BR and an undecodable word
        run_instr({11'b11010110000, 11'h7C0, 5'd12, 5'd0}, 1'b0, 1'b0, 4'h0);
        run_instr(32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0);

        // Saturation: 2^CNT_WIDTH taken branches, then one more
        do_reset();
        for (int i = 0; i < (1 << CNT_WIDTH) + 1; i++) begin
            run_instr({6'b000101, 26'h3FFFFFC}, 1'b0, 1'b0, 4'h0);
        end
        check("sat_bcnt", 64'(branch_cnt), 64'(CNT_MAX));
        check("sat_tcnt", 64'(taken_cnt),  64'(CNT_MAX));

        // Reset pulse while in LINK aborts the sequence
        @(negedge clock);
        instruction = {6'b100101, 26'h0000040};
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("abort_link_psel", 64'(Psel), 64'(3));
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy),       64'(0));
        check("abort_bcnt", 64'(branch_cnt), 64'(0));
        check("abort_tcnt", 64'(taken_cnt),  64'(0));
        check_quiet("abort");
        m_flags = 4'h0; m_branch = 0; m_taken = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_abort_busy", 64'(busy), 64'(0));
            check("post_abort_regw", 64'(regW), 64'(0));
            check("post_abort_enpc", 64'(EN_PC), 64'(0));
        end

        // Randomized instructions against the reference model
        for (int it = 0; it < 40; it++) begin
            if (it % 5 == 0) do_reset();
            if ($urandom_range(0, 2) == 0) load_flags(4'($urandom));
            rnd = $urandom;
            case ($urandom_range(0, 6))
                0: ins = {6'b000101, rnd[25:0]};
                1: ins = {6'b100101, rnd[25:0]};
                2: ins = {8'b01010100, rnd[23:0]};
                3: ins = {8'b10110100, rnd[23:0]};
                4: ins = {8'b10110101, rnd[23:0]};
                5: ins = {11'b11010110000, rnd[20:0]};
                default: ins = rnd;
            endcase
            run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have parameter K_WIDTH, default 64, giving the width of the sign-extended branch offset K.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each branch statistics counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clock: input, 1 bit, rising-edge clock.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start: input, 1 bit, request to sequence a branch instruction; sampled only in IDLE.
REQ-007 Port instruction: input, 32 bits, branch instruction; held stable from the start cycle until done.
REQ-008 Port status_in: input, 4 bits, {V,C,Z,N} from the ALU.
REQ-009 Port status_load: input, 1 bit, loads status_in into the flags register.
REQ-010 Port reg_zero: input, 1 bit, high when the register read on SB is zero (CBZ/CBNZ).
REQ-011 Port Psel: output, 2 bits: 00 hold, 01 PC+4, 11 PC+4+K*4, 10 PC from bus.
REQ-012 Ports PCsel, regW, EN_PC: outputs, 1 bit each; DA, SB: outputs, 5 bits each.
REQ-013 Port K: output, K_WIDTH bits, sign-extended immediate.
REQ-014 Ports busy, done, illegal: outputs, 1 bit each.
REQ-015 Port flags: output, 4 bits, registered {V,C,Z,N}.
REQ-016 Ports branch_cnt and taken_cnt: outputs, CNT_WIDTH bits each.

Function
REQ-017 The flags register SHALL load status_in on any clock edge with status_load=1, independent of FSM state.
REQ-018 The FSM SHALL have states IDLE, EVAL, LINK and DONE.
REQ-019 In IDLE with start=1, the FSM SHALL go to EVAL; otherwise it SHALL stay in IDLE.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 The block SHALL decode opcodes as follows: B = instr[31:26]=000101; BL = 100101; B.cond = instr[31:24]=01010100; CBZ = 10110100; CBNZ = 10110101; BR = instr[31:21]=11010110000.
REQ-022 K SHALL be the sign extension of instr[25:0] for B/BL, of instr[23:5] for B.cond/CBZ/CBNZ, and all zeros otherwise.
REQ-023 B.cond SHALL evaluate instr[3:0] using the registered flags: 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE ~(GT); E and F always true.
REQ-024 The flags used by EVAL SHALL be the register value before any status_load in that same cycle.
REQ-025 CBZ SHALL be taken when reg_zero=1; CBNZ SHALL be taken when reg_zero=0; B and BR SHALL always be taken.
REQ-026 In EVAL, SB SHALL equal instr[4:0] for CBZ/CBNZ and instr[9:5] for BR, and 5'b11111 otherwise.
REQ-027 EVAL, non-BL: EN_PC=1; Psel=11 if taken, 01 if not taken, 10 for BR; PCsel=1 for any taken relative branch; next state DONE.
REQ-028 EVAL, BL: regW=1, DA=30, EN_PC=1 (PC+4 driven to bus), Psel=00; next state LINK.
REQ-029 LINK: Psel=11, PCsel=1, regW=0; next state DONE.
REQ-030 EVAL with an undecodable opcode: illegal=1 for that cycle, Psel=01, not counted; next state DONE.
REQ-031 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-032 busy SHALL be 1 in EVAL, LINK and DONE.
REQ-033 Outside the states listed in REQ-027 to REQ-029, the outputs SHALL be: Psel=00, PCsel=0, regW=0, EN_PC=0, DA=SB=11111.
REQ-034 branch_cnt SHALL increment once per legal branch in EVAL; taken_cnt SHALL increment once per taken branch; both SHALL saturate at all ones.

Reset
REQ-035 reset_n=0 SHALL asynchronously force the state to IDLE and clear flags, branch_cnt and taken_cnt to 0.
REQ-036 While reset_n=0, the outputs SHALL be: busy=0, done=0, illegal=0, Psel=00, PCsel=0, regW=0, EN_PC=0, DA=SB=11111, K=0.
REQ-037 A reset asserted mid-sequence (EVAL or LINK) SHALL abort the sequence with no further regW or EN_PC pulse after release.

Verification
REQ-038 Load flags=0010 (Z), then start B.cond EQ with imm19=-1 -> EVAL: Psel=11, PCsel=1, K=all ones; done asserted 2 cycles after start; taken_cnt=1.
REQ-039 flags N=1, V=0, B.cond GE -> Psel=01, PCsel=0; branch_cnt=1, taken_cnt=0.
REQ-040 BL with imm26=0x0000010 -> EVAL: regW=1, DA=30; LINK: Psel=11, K=16; done 3 cycles after start.
REQ-041 CBNZ with reg_zero=1 -> Psel=01, not taken; CBZ with reg_zero=1 -> Psel=11.
REQ-042 status_load with status_in=0000 in the same cycle as EVAL of B.cond EQ, with prior flags Z=1 -> taken; flags read 0000 afterwards.
REQ-043 Preset counters to all ones via 2^CNT_WIDTH taken branches (CNT_WIDTH=2: 4 branches) -> counters hold 11; a second start during busy is ignored; reset_n pulse in LINK -> IDLE, counters 0.
